// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HUNT = 1'b1
    } seq_state_e;

    localparam int            SEQ_DEF_MAX_LEN = 8;
    localparam logic [7:0]    SEQ_DEF_PATTERN = 8'b0000_0111;
    localparam int            SEQ_DEF_LEN     = 3;
    localparam logic          SEQ_DEF_OVERLAP = 1'b0;

    // Width needed to hold a length in 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Masked compare of the newest len bits ({hist, xin}) against the right-aligned pattern.
module seq_match_cmp
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic [MAX_LEN-2:0]      hist,
    input  logic                    xin,
    input  logic [MAX_LEN-1:0]      pat,
    input  logic [$clog2(MAX_LEN):0] len,
    output logic                    eq
);

    localparam int LW = len_w(MAX_LEN);

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;

    assign window = {hist, xin};

    // Bits at or above len are don't-care.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign mask[gi] = (len > LW'(gi));
        end
    endgenerate

    assign eq = (((window ^ pat) & mask) == '0);

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial bit-pattern detector with overlap control, Mealy/registered
// match outputs and a saturating match counter.
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_0111),
    parameter int                 DEF_LEN     = 3,
    parameter logic               DEF_OVERLAP = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_load,
    input  logic [MAX_LEN-1:0]       cfg_pattern,
    input  logic [$clog2(MAX_LEN):0] cfg_len,
    input  logic                     cfg_overlap,
    input  logic                     xin_valid,
    input  logic                     xin,
    output logic                     y,
    output logic                     y_q,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     cfg_err
);

    localparam int            LW       = len_w(MAX_LEN);
    localparam logic [LW-1:0] MAX_FILL = LW'(MAX_LEN);
    localparam logic [LW-1:0] RST_LEN  = LW'(DEF_LEN);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic               ovl_q, ovl_d;
    // The oldest bit of a MAX_LEN window is xin's predecessor MAX_LEN-1 deep,
    // so only MAX_LEN-1 past bits are ever compared.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               y_q_q, y_q_d;
    logic               cfg_err_q, cfg_err_d;
    seq_state_e         state_q, state_d;

    logic cmp_eq;
    logic cfg_legal;

    function automatic seq_state_e state_of(input logic [LW-1:0] fill,
                                            input logic [LW-1:0] len);
        // fill >= len-1, evaluated without underflow
        return ((LW+1)'(fill) + (LW+1)'(1) >= (LW+1)'(len)) ? ST_HUNT : ST_FILL;
    endfunction

    seq_match_cmp #(
        .MAX_LEN (MAX_LEN)
    ) u_cmp (
        .hist (hist_q),
        .xin  (xin),
        .pat  (pat_q),
        .len  (len_q),
        .eq   (cmp_eq)
    );

    assign cfg_legal = (cfg_len != '0) && (cfg_len <= MAX_FILL);

    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        cfg_err_d = 1'b0;
        y         = 1'b0;

        if (reset) begin
            y = 1'b0;
        end else if (cfg_load && cfg_legal) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else begin
            cfg_err_d = cfg_load;
            if (xin_valid) begin
                y      = (state_q == ST_HUNT) && cmp_eq;
                hist_d = {hist_q[MAX_LEN-3:0], xin};
                if (y && !ovl_q) begin
                    fill_d = '0;
                end else if (fill_q != MAX_FILL) begin
                    fill_d = fill_q + LW'(1);
                end
            end
            if (y && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        y_q_d   = y;
        state_d = state_of(fill_d, len_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q     <= DEF_PATTERN;
            len_q     <= RST_LEN;
            ovl_q     <= DEF_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            y_q_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            state_q   <= state_of('0, RST_LEN);
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            y_q_q     <= y_q_d;
            cfg_err_q <= cfg_err_d;
            state_q   <= state_d;
        end
    end

    assign y_q       = y_q_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed self-checking bench for seq_det_prog (default build plus a 2-bit counter build).
module tb_seq_det_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       xin_valid;
    logic       xin;

    logic       y, y_q, cfg_err;
    logic [7:0] match_cnt;
    logic       y2, y_q2, cfg_err2;
    logic [1:0] match_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_det_prog dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .xin_valid(xin_valid), .xin(xin),
        .y(y), .y_q(y_q), .match_cnt(match_cnt), .cfg_err(cfg_err)
    );

    seq_det_prog #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .xin_valid(xin_valid), .xin(xin),
        .y(y2), .y_q(y_q2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
    );

    // One clock: inputs applied after a falling edge, y sampled before the rising edge,
    // registered outputs observable on return.
    task automatic cycle(input logic ld, input logic [7:0] p, input logic [3:0] l,
                         input logic o, input logic v, input logic b, output logic ys);
        cfg_load = ld; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        xin_valid = v; xin = b;
        #1;
        ys = y;
        $display("cycle ld=%0b len=%0d v=%0b x=%0b -> y=%0b", ld, l, v, b, ys);
        @(posedge clk);
        #1;
        cfg_load = 1'b0; xin_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic bit_in(input logic b, output logic ys);
        cycle(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, ys);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        logic ys;
        cycle(1'b1, p, l, o, 1'b0, 1'b0, ys);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset;
        logic ys;
        reset = 1'b1;
        cycle(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, ys);
        n_checks++;
        if (ys !== 1'b0) begin n_fail++; $display("FAIL reset_y: got %0b expected 0", ys); end
        cycle(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, ys);
        reset = 1'b0;
        n_checks++;
        if (y_q !== 1'b0) begin n_fail++; $display("FAIL reset_y_q: got %0b expected 0", y_q); end
        n_checks++;
        if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt); end
        n_checks++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %0b expected 0", cfg_err); end
        n_checks++;
        if (match_cnt2 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt2: got %0d expected 0", match_cnt2); end
    endtask

    task automatic test_default;
        logic ys;
        logic exp_y [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            bit_in(1'b1, ys);
            n_checks++;
            if (ys !== exp_y[i]) begin n_fail++; $display("FAIL default_y[%0d]: got %0b expected %0b", i, ys, exp_y[i]); end
            n_checks++;
            if (y_q !== exp_y[i]) begin n_fail++; $display("FAIL default_y_q[%0d]: got %0b expected %0b", i, y_q, exp_y[i]); end
        end
        n_checks++;
        if (match_cnt !== 8'd2) begin n_fail++; $display("FAIL default_cnt: got %0d expected 2", match_cnt); end
    endtask

    task automatic test_overlap;
        logic ys;
        logic stim  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic exp_o [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic exp_n [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        load(8'b1011, 4'd4, 1'b1);
        n_checks++;
        if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL ovl_load_cnt: got %0d expected 0", match_cnt); end
        for (int i = 0; i < 7; i++) begin
            bit_in(stim[i], ys);
            n_checks++;
            if (ys !== exp_o[i]) begin n_fail++; $display("FAIL ovl1_y[%0d]: got %0b expected %0b", i, ys, exp_o[i]); end
        end
        n_checks++;
        if (match_cnt !== 8'd2) begin n_fail++; $display("FAIL ovl1_cnt: got %0d expected 2", match_cnt); end
        load(8'b1011, 4'd4, 1'b0);
        for (int i = 0; i < 7; i++) begin
            bit_in(stim[i], ys);
            n_checks++;
            if (ys !== exp_n[i]) begin n_fail++; $display("FAIL ovl0_y[%0d]: got %0b expected %0b", i, ys, exp_n[i]); end
        end
        n_checks++;
        if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL ovl0_cnt: got %0d expected 1", match_cnt); end
    endtask

    task automatic test_gaps;
        logic ys;
        logic stim [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        load(8'b1011, 4'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bit_in(stim[i], ys);
            n_checks++;
            if (ys !== (i == 3)) begin n_fail++; $display("FAIL gap_y[%0d]: got %0b expected %0b", i, ys, (i == 3)); end
            for (int k = 0; k < 3; k++) begin
                cycle(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, ys);
                n_checks++;
                if (ys !== 1'b0) begin n_fail++; $display("FAIL gap_idle_y[%0d.%0d]: got %0b expected 0", i, k, ys); end
            end
        end
        n_checks++;
        if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL gap_cnt: got %0d expected 1", match_cnt); end
    endtask

    task automatic test_cfg_err;
        logic ys;
        load(8'b1011, 4'd4, 1'b1);
        bit_in(1'b1, ys); bit_in(1'b0, ys); bit_in(1'b1, ys);
        // illegal length 0 on the completing bit: bit still processed
        cycle(1'b1, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, ys);
        n_checks++;
        if (ys !== 1'b1) begin n_fail++; $display("FAIL err0_y: got %0b expected 1", ys); end
        n_checks++;
        if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err0_pulse: got %0b expected 1", cfg_err); end
        n_checks++;
        if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL err0_cnt: got %0d expected 1", match_cnt); end
        cycle(1'b1, 8'h00, 4'd9, 1'b0, 1'b1, 1'b0, ys);
        n_checks++;
        if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err9_pulse: got %0b expected 1", cfg_err); end
        n_checks++;
        if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL err9_cnt: got %0d expected 1", match_cnt); end
        cycle(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, ys);
        n_checks++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %0b expected 0", cfg_err); end
        bit_in(1'b1, ys);
        bit_in(1'b1, ys);
        n_checks++;
        if (ys !== 1'b1) begin n_fail++; $display("FAIL err_cont_y: got %0b expected 1", ys); end
        chk("err_cont_cnt", match_cnt, 2);
    endtask

    task automatic test_reset_mid;
        logic ys;
        reset = 1'b1; cycle(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, ys); reset = 1'b0;
        bit_in(1'b1, ys); bit_in(1'b1, ys);
        reset = 1'b1; cycle(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, ys); reset = 1'b0;
        chk("rst_mid_cnt", match_cnt, 0);
        bit_in(1'b1, ys); chk("rst_mid_y1", ys, 0);
        bit_in(1'b1, ys); chk("rst_mid_y2", ys, 0);
        bit_in(1'b1, ys); chk("rst_mid_y3", ys, 1);
        chk("rst_mid_cnt_after", match_cnt, 1);
    endtask

    task automatic test_saturate;
        logic ys;
        int exp2 [5] = '{1, 2, 3, 3, 3};
        load(8'b0000_0001, 4'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bit_in(1'b1, ys);
            chk($sformatf("sat_y[%0d]", i), ys, 1);
            chk($sformatf("sat_cnt2[%0d]", i), match_cnt2, exp2[i]);
            chk($sformatf("sat_cnt8[%0d]", i), match_cnt, i + 1);
        end
        bit_in(1'b0, ys);
        chk("sat_zero_y", ys, 0);
        chk("sat_hold_cnt2", match_cnt2, 3);
    endtask

    task automatic test_load_collision;
        logic ys;
        load(8'b0000_0111, 4'd3, 1'b0);
        bit_in(1'b1, ys); bit_in(1'b1, ys);
        cycle(1'b1, 8'b0000_0111, 4'd3, 1'b1, 1'b1, 1'b1, ys);
        chk("coll_y", ys, 0);
        chk("coll_cnt", match_cnt, 0);
        chk("coll_y_q", y_q, 0);
        bit_in(1'b1, ys); chk("coll_after_y1", ys, 0);
        bit_in(1'b1, ys); chk("coll_after_y2", ys, 0);
        bit_in(1'b1, ys); chk("coll_after_y3", ys, 1);
        bit_in(1'b1, ys); chk("coll_after_ovl_y4", ys, 1);
    endtask

    initial begin
        reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; xin_valid = 1'b0; xin = 1'b0;
        @(negedge clk);
        test_reset;
        test_default;
        test_overlap;
        test_gaps;
        test_cfg_err;
        test_reset_mid;
        test_saturate;
        test_load_collision;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
